// File: rtl/cache_arb_pkg.sv
// Shared types for the cache request arbiter.
//   - arb_state_e : arbiter FSM states
//   - req_id_e    : requester identity (fetch / load-store)
//   - arb_req_t   : request captured at grant time and held for the whole transaction
package cache_arb_pkg;

    localparam int unsigned ADR_W  = 32;
    localparam int unsigned MEM_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    typedef struct packed {
        req_id_e             owner;
        logic                we;
        logic [ADR_W-1:0]    adr;
        logic [MEM_DW-1:0]   wdata;
        logic [3:0]          strobe;
    } arb_req_t;

    // The cache only handles word accesses.
    function automatic logic is_misaligned(input logic [ADR_W-1:0] adr);
        return adr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Bus bundle around the cache request arbiter.
//   if_*  : instruction-fetch request/response (read-only)
//   ls_*  : load/store request/response (read/write)
//   mem_* : single-transaction interface to the shared cache
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding core + cache (the environment)
interface cache_req_arbiter_if #(
    parameter int unsigned XLEN = 32
);

    logic            if_req_valid;
    logic            if_req_ready;
    logic [31:0]     if_adr;
    logic            if_rsp_valid;
    logic [XLEN-1:0] if_rsp_data;
    logic            if_rsp_err;

    logic            ls_req_valid;
    logic            ls_req_ready;
    logic            ls_we;
    logic [31:0]     ls_adr;
    logic [XLEN-1:0] ls_wdata;
    logic [3:0]      ls_strobe;
    logic            ls_rsp_valid;
    logic [XLEN-1:0] ls_rsp_data;
    logic            ls_rsp_err;

    logic            mem_r_v;
    logic            mem_w_v;
    logic [31:0]     mem_adr;
    logic [31:0]     mem_data;
    logic [3:0]      mem_strobe;
    logic [XLEN-1:0] mem_resp;
    logic            mem_resp_valid;

    modport slave (
        input  if_req_valid, if_adr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  ls_req_valid, ls_we, ls_adr, ls_wdata, ls_strobe,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        output mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
        input  mem_resp, mem_resp_valid
    );

    modport master (
        output if_req_valid, if_adr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output ls_req_valid, ls_we, ls_adr, ls_wdata, ls_strobe,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        input  mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
        output mem_resp, mem_resp_valid
    );

endinterface

// File: rtl/cache_req_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req[1:0]   : request lines
//   advance    : a grant was taken this cycle; move the pointer
//   gnt[1:0]   : one-hot grant (zero when no request)
// ptr_q names the requester that wins when both request. After a taken grant
// the pointer moves to the requester that was not granted.
module rr_arb2 #(
    parameter bit PTR_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PTR_INIT;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache between the fetch port and the load/store port.
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   bus        : fetch / load-store request+response and cache bus (slave modport)
// One transaction at a time: grant in IDLE, one-cycle cache strobe in ISSUE,
// wait for read data (with timeout) in WAIT, one-cycle response pulse in RESP.
// Misaligned requests skip the cache and respond with an error.
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TIMEOUT  = 8,
    parameter bit          LS_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    cache_req_arbiter_if.slave bus
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e      state_q, state_d;
    arb_req_t        req_q, req_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            mem_r_v_q, mem_r_v_d;
    logic            mem_w_v_q, mem_w_v_d;
    // Per-port copies so rsp_data holds its last value between pulses.
    logic [XLEN-1:0] if_data_q, if_data_d;
    logic [XLEN-1:0] ls_data_q, ls_data_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_advance;

    // Requests are only offered in IDLE, so a grant only ever happens there.
    assign arb_req     = {bus.ls_req_valid, bus.if_req_valid}
                       & {2{(state_q == IDLE) && rst_n}};
    assign arb_advance = (state_q == IDLE) && (arb_gnt != 2'b00);

    rr_arb2 #(
        .PTR_INIT (LS_FIRST)
    ) u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            mem_r_v_q <= 1'b0;
            mem_w_v_q <= 1'b0;
            if_data_q <= '0;
            ls_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            err_q     <= err_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            mem_r_v_q <= mem_r_v_d;
            mem_w_v_q <= mem_w_v_d;
            if_data_q <= if_data_d;
            ls_data_q <= ls_data_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        err_d     = err_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        mem_r_v_d = 1'b0;
        mem_w_v_d = 1'b0;
        if_data_d = if_data_q;
        ls_data_d = ls_data_q;

        unique case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    if (arb_gnt[1]) begin
                        req_d.owner  = REQ_LS;
                        req_d.we     = bus.ls_we;
                        req_d.adr    = bus.ls_adr;
                        req_d.wdata  = bus.ls_wdata[MEM_DW-1:0];
                        req_d.strobe = bus.ls_strobe;
                    end else begin
                        req_d.owner  = REQ_IF;
                        req_d.we     = 1'b0;
                        req_d.adr    = bus.if_adr;
                        req_d.wdata  = '0;
                        req_d.strobe = '0;
                    end
                    data_d = '0;
                    if (is_misaligned(req_d.adr)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d     = 1'b0;
                        state_d   = ISSUE;
                        mem_r_v_d = !req_d.we;
                        mem_w_v_d = req_d.we;
                    end
                end
            end
            ISSUE: begin
                if (req_q.we) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the timeout cycle still wins.
                if (bus.mem_resp_valid) begin
                    data_d  = bus.mem_resp;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (req_q.owner == REQ_IF) begin
                    if_data_d = data_q;
                end else begin
                    ls_data_d = data_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        logic if_rsp;
        logic ls_rsp;
        if_rsp = (state_q == RESP) && (req_q.owner == REQ_IF);
        ls_rsp = (state_q == RESP) && (req_q.owner == REQ_LS);

        bus.if_req_ready = arb_gnt[0];
        bus.ls_req_ready = arb_gnt[1];

        bus.mem_r_v    = mem_r_v_q;
        bus.mem_w_v    = mem_w_v_q;
        bus.mem_adr    = req_q.adr;
        bus.mem_data   = req_q.wdata;
        bus.mem_strobe = req_q.strobe;

        bus.if_rsp_valid = if_rsp;
        bus.if_rsp_err   = if_rsp && err_q;
        bus.if_rsp_data  = if_rsp ? data_q : if_data_q;

        bus.ls_rsp_valid = ls_rsp;
        bus.ls_rsp_err   = ls_rsp && err_q;
        bus.ls_rsp_data  = ls_rsp ? data_q : ls_data_q;
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cache_req_arbiter_if #(.XLEN(XLEN)) bus ();

    cache_req_arbiter #(
        .XLEN     (XLEN),
        .TIMEOUT  (TIMEOUT),
        .LS_FIRST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Cache model: samples strobes on the falling edge, answers a read at the next rising edge.
    logic [31:0] mem [32];
    logic        mem_init = 1'b0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_data = '0;
    logic        withhold = 1'b0;
    logic        late_pulse = 1'b0;
    int          r_cnt = 0;
    int          w_cnt = 0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 + i;
            mem_init <= 1'b1;
        end
        rd_pend <= bus.mem_r_v;
        if (bus.mem_r_v) begin
            r_cnt   <= r_cnt + 1;
            rd_data <= mem[bus.mem_adr[6:2]];
        end
        if (bus.mem_w_v) begin
            w_cnt <= w_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (bus.mem_strobe[b]) mem[bus.mem_adr[6:2]][8*b +: 8] <= bus.mem_data[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        bus.mem_resp_valid <= 1'b0;
        if ((rd_pend && !withhold) || late_pulse) begin
            bus.mem_resp_valid <= 1'b1;
            bus.mem_resp       <= late_pulse ? 32'h1234_5678 : rd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.mem_r_v !== 1'b0 || bus.mem_w_v !== 1'b0) begin
            n_errors++; $display("FAIL reset_mem_v: got r=%b w=%b want 0 0", bus.mem_r_v, bus.mem_w_v); end
        n_checks++; if (bus.mem_adr !== 32'h0 || bus.mem_data !== 32'h0 || bus.mem_strobe !== 4'h0) begin
            n_errors++; $display("FAIL reset_mem_bus: got adr=%h data=%h strb=%h want 0", bus.mem_adr, bus.mem_data, bus.mem_strobe); end
        n_checks++; if ({bus.if_rsp_valid, bus.if_rsp_err, bus.ls_rsp_valid, bus.ls_rsp_err} !== 4'b0) begin
            n_errors++; $display("FAIL reset_rsp: got %b want 0000", {bus.if_rsp_valid, bus.if_rsp_err, bus.ls_rsp_valid, bus.ls_rsp_err}); end
        n_checks++; if (bus.if_rsp_data !== 32'h0 || bus.ls_rsp_data !== 32'h0) begin
            n_errors++; $display("FAIL reset_rsp_data: got if=%h ls=%h want 0", bus.if_rsp_data, bus.ls_rsp_data); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle_ready: got if=%b ls=%b want 0 0", bus.if_req_ready, bus.ls_req_ready); end
    endtask

    // Contention after reset: LS write wins first, then fetch reads the written word.
    task automatic test_write_then_fetch();
        bus.if_req_valid = 1'b1; bus.if_adr = 32'h0002_0010;
        bus.ls_req_valid = 1'b1; bus.ls_we = 1'b1; bus.ls_adr = 32'h0002_0010;
        bus.ls_wdata = 32'hDEAD_BEEF; bus.ls_strobe = 4'hF;
        #1;
        n_checks++; if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0) begin
            n_errors++; $display("FAIL arb_first_ls: got ls=%b if=%b want 1 0", bus.ls_req_ready, bus.if_req_ready); end
        tick();
        bus.ls_req_valid = 1'b0;
        n_checks++; if (bus.mem_w_v !== 1'b1 || bus.mem_r_v !== 1'b0) begin
            n_errors++; $display("FAIL wr_issue_strobe: got w=%b r=%b want 1 0", bus.mem_w_v, bus.mem_r_v); end
        n_checks++; if (bus.mem_adr !== 32'h0002_0010 || bus.mem_data !== 32'hDEAD_BEEF || bus.mem_strobe !== 4'hF) begin
            n_errors++; $display("FAIL wr_issue_bus: got adr=%h data=%h strb=%h want 00020010 deadbeef f", bus.mem_adr, bus.mem_data, bus.mem_strobe); end
        n_checks++; if (bus.if_req_ready !== 1'b0) begin
            n_errors++; $display("FAIL busy_no_ready: got %b want 0", bus.if_req_ready); end
        tick();
        n_checks++; if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_err !== 1'b0 || bus.mem_w_v !== 1'b0) begin
            n_errors++; $display("FAIL wr_resp: got valid=%b err=%b w=%b want 1 0 0", bus.ls_rsp_valid, bus.ls_rsp_err, bus.mem_w_v); end
        n_checks++; if (bus.if_rsp_valid !== 1'b0 || bus.mem_r_v !== 1'b0) begin
            n_errors++; $display("FAIL wr_resp_other: got if_valid=%b r=%b want 0 0", bus.if_rsp_valid, bus.mem_r_v); end
        tick();
        n_checks++; if (bus.ls_rsp_valid !== 1'b0 || bus.if_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL arb_second_if: got ls_valid=%b if_ready=%b want 0 1", bus.ls_rsp_valid, bus.if_req_ready); end
        tick();
        bus.if_req_valid = 1'b0;
        n_checks++; if (bus.mem_r_v !== 1'b1 || bus.mem_w_v !== 1'b0 || bus.mem_adr !== 32'h0002_0010) begin
            n_errors++; $display("FAIL rd_issue: got r=%b w=%b adr=%h want 1 0 00020010", bus.mem_r_v, bus.mem_w_v, bus.mem_adr); end
        tick();
        n_checks++; if (bus.if_rsp_valid !== 1'b0 || bus.mem_r_v !== 1'b0) begin
            n_errors++; $display("FAIL rd_wait: got valid=%b r=%b want 0 0", bus.if_rsp_valid, bus.mem_r_v); end
        tick();
        n_checks++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_err !== 1'b0 || bus.if_rsp_data !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL rd_resp: got valid=%b err=%b data=%h want 1 0 deadbeef", bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data); end
        tick();
        n_checks++; if (bus.if_rsp_valid !== 1'b0 || bus.if_rsp_err !== 1'b0 || bus.if_rsp_data !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL rd_hold: got valid=%b err=%b data=%h want 0 0 deadbeef", bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data); end
    endtask

    // Third and fourth grants: misaligned LS read (wins), then fetch.
    task automatic test_misaligned();
        int r0, w0;
        r0 = r_cnt; w0 = w_cnt;
        bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_adr = 32'h0002_0012;
        bus.if_req_valid = 1'b1; bus.if_adr = 32'h0002_0014;
        #1;
        n_checks++; if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0) begin
            n_errors++; $display("FAIL arb_third_ls: got ls=%b if=%b want 1 0", bus.ls_req_ready, bus.if_req_ready); end
        tick();
        bus.ls_req_valid = 1'b0;
        n_checks++; if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_err !== 1'b1) begin
            n_errors++; $display("FAIL mis_resp: got valid=%b err=%b want 1 1", bus.ls_rsp_valid, bus.ls_rsp_err); end
        tick();
        n_checks++; if (bus.ls_rsp_valid !== 1'b0 || bus.ls_rsp_err !== 1'b0 || bus.if_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL arb_fourth_if: got ls_valid=%b ls_err=%b if_ready=%b want 0 0 1", bus.ls_rsp_valid, bus.ls_rsp_err, bus.if_req_ready); end
        n_checks++; if (r_cnt != r0 || w_cnt != w0) begin
            n_errors++; $display("FAIL mis_no_mem: got reads=%0d writes=%0d want 0 0", r_cnt - r0, w_cnt - w0); end
        tick();
        bus.if_req_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_err !== 1'b0 || bus.if_rsp_data !== 32'hA500_0005) begin
            n_errors++; $display("FAIL fourth_rd_resp: got valid=%b err=%b data=%h want 1 0 a5000005", bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data); end
        n_checks++; if (r_cnt != r0 + 1 || w_cnt != w0) begin
            n_errors++; $display("FAIL fourth_rd_count: got reads=%0d writes=%0d want 1 0", r_cnt - r0, w_cnt - w0); end
        tick();
    endtask

    task automatic test_timeout();
        int  cyc;
        bit  seen;
        bit  stray;
        // Good read first so the error data of the timed-out read is distinguishable.
        bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_adr = 32'h0002_001C;
        #1;
        tick();
        bus.ls_req_valid = 1'b0;
        tick(); tick();
        n_checks++; if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_data !== 32'hA500_0007) begin
            n_errors++; $display("FAIL ls_rd_resp: got valid=%b data=%h want 1 a5000007", bus.ls_rsp_valid, bus.ls_rsp_data); end
        tick();
        withhold = 1'b1;
        bus.ls_req_valid = 1'b1; bus.ls_adr = 32'h0002_0018;
        #1;
        n_checks++; if (bus.ls_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL to_accept: got %b want 1", bus.ls_req_ready); end
        tick();
        bus.ls_req_valid = 1'b0;
        cyc = 1; seen = 1'b0;
        while (cyc < 20 && !seen) begin
            tick();
            cyc++;
            if (bus.ls_rsp_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen || cyc != 10) begin
            n_errors++; $display("FAIL to_latency: got seen=%b cycle=%0d want 1 10", seen, cyc); end
        n_checks++; if (bus.ls_rsp_err !== 1'b1 || bus.ls_rsp_data !== 32'h0) begin
            n_errors++; $display("FAIL to_resp: got err=%b data=%h want 1 0", bus.ls_rsp_err, bus.ls_rsp_data); end
        tick();
        withhold = 1'b0;
        late_pulse = 1'b1;
        tick();
        late_pulse = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            tick();
            if (bus.ls_rsp_valid !== 1'b0 || bus.if_rsp_valid !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) begin
            n_errors++; $display("FAIL late_resp_ignored: got stray=%b want 0", stray); end
    endtask

    task automatic test_reset_mid_wait();
        bit stray;
        withhold = 1'b1;
        bus.if_req_valid = 1'b1; bus.if_adr = 32'h0002_0010;
        #1;
        tick();
        bus.if_req_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        withhold = 1'b0;
        n_checks++; if (bus.mem_r_v !== 1'b0 || bus.mem_w_v !== 1'b0 || bus.mem_adr !== 32'h0) begin
            n_errors++; $display("FAIL rst_wait_mem: got r=%b w=%b adr=%h want 0 0 0", bus.mem_r_v, bus.mem_w_v, bus.mem_adr); end
        n_checks++; if (bus.if_rsp_valid !== 1'b0 || bus.if_rsp_data !== 32'h0 || bus.ls_rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL rst_wait_rsp: got if_valid=%b if_data=%h ls_valid=%b want 0 0 0", bus.if_rsp_valid, bus.if_rsp_data, bus.ls_rsp_valid); end
        late_pulse = 1'b1;
        tick();
        late_pulse = 1'b0;
        stray = 1'b0;
        repeat (12) begin
            tick();
            if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) begin
            n_errors++; $display("FAIL rst_aborted_no_rsp: got stray=%b want 0", stray); end
        bus.if_req_valid = 1'b1; bus.if_adr = 32'h0002_0010;
        #1;
        n_checks++; if (bus.if_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL post_rst_accept: got %b want 1", bus.if_req_ready); end
        tick();
        bus.if_req_valid = 1'b0;
        tick(); tick();
        n_checks++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_err !== 1'b0 || bus.if_rsp_data !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL post_rst_resp: got valid=%b err=%b data=%h want 1 0 deadbeef", bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data); end
        tick();
    endtask

    initial begin
        bus.if_req_valid = 1'b0; bus.if_adr = '0;
        bus.ls_req_valid = 1'b0; bus.ls_we = 1'b0; bus.ls_adr = '0;
        bus.ls_wdata = '0; bus.ls_strobe = '0;
        test_reset();
        test_write_then_fetch();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
